// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and table sizing helper.
package tts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tts_state_e;

    // Number of entries in a truth table for a function of n inputs.
    function automatic int unsigned tbl_width(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// Loadable down-counter that paces how long each input vector is held before it is sampled.
module tts_settle_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Counter register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/capture engine for a small combinational function; compares against EXPECTED.
// Optional build macro TTS_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter logic [tbl_width(N_IN)-1:0] EXPECTED = 16'h1F55
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       dut_f,
    output logic [N_IN-1:0]            vec_out,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [tbl_width(N_IN)-1:0] table_out,
    output logic [tbl_width(N_IN)-1:0] mismatch_mask,
    output logic [N_IN:0]              err_count
);

    localparam int TBL_W = tbl_width(N_IN);
    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  VEC_ONE       = N_IN'(32'd1);
    localparam logic [N_IN-1:0]  VEC_LAST      = N_IN'(TBL_W - 1);

    tts_state_e         state_r;
    tts_state_e         state_next_s;
    logic [N_IN-1:0]    vec_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [TBL_W-1:0]   table_r;
    logic [TBL_W-1:0]   mask_r;
    logic [N_IN:0]      err_r;

    logic               miss_s;
    logic               last_s;
    logic               stop_s;
    logic [N_IN:0]      err_next_s;
    logic               timer_load_s;
    logic               timer_dec_s;
    logic               timer_zero_s;

    assign miss_s     = dut_f ^ EXPECTED[vec_r];
    assign last_s     = (vec_r == VEC_LAST);
    assign err_next_s = err_r + {{N_IN{1'b0}}, miss_s};

`ifdef TTS_STOP_ON_FAIL_EN
    assign stop_s = miss_s;
`else
    assign stop_s = 1'b0;
`endif

    tts_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load_s),
        .load_val (SETTLE_RELOAD),
        .dec      (timer_dec_s),
        .zero     (timer_zero_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_SETTLE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (timer_zero_s) begin
                    state_next_s = ST_SAMPLE;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (last_s || stop_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM control outputs driving the settle timer.
    always_comb begin
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_load_s = start;
            end
            ST_SETTLE: begin
                timer_dec_s = ~timer_zero_s;
            end
            ST_SAMPLE: begin
                timer_load_s = (state_next_s == ST_SETTLE);
            end
            ST_DONE: begin
                timer_load_s = 1'b0;
            end
            default: begin
                timer_load_s = 1'b0;
                timer_dec_s  = 1'b0;
            end
        endcase
    end

    // Vector generation, capture and comparison; verdict is registered on the way into DONE
    // so it already includes the final sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_r   <= {N_IN{1'b0}};
            pass_r  <= 1'b0;
            table_r <= {TBL_W{1'b0}};
            mask_r  <= {TBL_W{1'b0}};
            err_r   <= {(N_IN+1){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        vec_r   <= {N_IN{1'b0}};
                        pass_r  <= 1'b0;
                        table_r <= {TBL_W{1'b0}};
                        mask_r  <= {TBL_W{1'b0}};
                        err_r   <= {(N_IN+1){1'b0}};
                    end
                end
                ST_SAMPLE: begin
                    table_r[vec_r] <= dut_f;
                    mask_r[vec_r]  <= miss_s;
                    err_r          <= err_next_s;
                    if (state_next_s == ST_DONE) begin
                        pass_r <= (err_next_s == {(N_IN+1){1'b0}});
                    end else begin
                        vec_r <= vec_r + VEC_ONE;
                    end
                end
                default: begin
                    vec_r <= vec_r;
                end
            endcase
        end
    end

    // Status flags follow the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign vec_out       = vec_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign table_out     = table_r;
    assign mismatch_mask = mask_r;
    assign err_count     = err_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed self-checking bench for truth_table_sweeper (default and SETTLE_CYCLES=3 instances).
`timescale 1ns/1ps
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start3;
    logic        dut_f;
    logic        dut_f3;
    logic [3:0]  vec_out, vec_out3;
    logic        busy, busy3, done, done3, pass, pass3;
    logic [15:0] table_out, table_out3, mismatch_mask, mismatch_mask3;
    logic [4:0]  err_count, err_count3;

    logic [15:0] exp_tbl = 16'h1F55;
    int          mode = 0;
    logic        f3_d1, f3_d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    truth_table_sweeper u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_f(dut_f),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .table_out(table_out), .mismatch_mask(mismatch_mask), .err_count(err_count)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .dut_f(dut_f3),
        .vec_out(vec_out3), .busy(busy3), .done(done3), .pass(pass3),
        .table_out(table_out3), .mismatch_mask(mismatch_mask3), .err_count(err_count3)
    );

    // Function-under-test models: 0 correct, 1 stuck-at-0, 2 bit 9 inverted.
    always_comb begin
        case (mode)
            1:       dut_f = 1'b0;
            2:       dut_f = exp_tbl[vec_out] ^ (vec_out == 4'd9);
            default: dut_f = exp_tbl[vec_out];
        endcase
    end

    // Slow function for the settle instance: output lags its input by two cycles.
    always @(posedge clk) begin
        f3_d1 <= exp_tbl[vec_out3];
        f3_d2 <= f3_d1;
    end
    assign dut_f3 = f3_d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int k;
        int run;
        int bad;
        int changes;
        int done_seen;
        logic pulsed;
        logic [3:0] prev;

        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_vec", vec_out, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_table", table_out, 16'h0000);
        chk("rst_mask", mismatch_mask, 16'h0000);
        chk("rst_err", err_count, 5'd0);

        // start coincident with rst is dropped
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_wins_busy", busy, 1'b0);
        tick();
        chk("rst_wins_busy2", busy, 1'b0);

        // correct function
        mode = 0;
        pulse_start();
        chk("t1_busy_after_start", busy, 1'b1);
        chk("t1_vec_first", vec_out, 4'd0);
        wait_done(n);
        chk("t1_latency", n, 32);
        chk("t1_pass", pass, 1'b1);
        chk("t1_table", table_out, 16'h1F55);
        chk("t1_mask", mismatch_mask, 16'h0000);
        chk("t1_err", err_count, 5'd0);
        chk("t1_vec_last", vec_out, 4'hF);
        chk("t1_busy_in_done", busy, 1'b1);
        tick();
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_busy_clear", busy, 1'b0);
        tick(); tick(); tick();
        chk("t1_pass_held", pass, 1'b1);
        chk("t1_vec_held", vec_out, 4'hF);

        // stuck-at-0
        mode = 1;
        pulse_start();
        chk("t2_pass_cleared", pass, 1'b0);
        chk("t2_table_cleared", table_out, 16'h0000);
        chk("t2_err_cleared", err_count, 5'd0);
        wait_done(n);
        chk("t2_pass", pass, 1'b0);
        chk("t2_table", table_out, 16'h0000);
`ifdef TTS_STOP_ON_FAIL_EN
        chk("t2_latency", n, 2);
        chk("t2_mask", mismatch_mask, 16'h0001);
        chk("t2_err", err_count, 5'd1);
        chk("t2_vec", vec_out, 4'd0);
`else
        chk("t2_latency", n, 32);
        chk("t2_mask", mismatch_mask, 16'h1F55);
        chk("t2_err", err_count, 5'd9);
`endif
        tick();

        // single-bit error at vector 9
        mode = 2;
        pulse_start();
        wait_done(n);
        chk("t3_pass", pass, 1'b0);
        chk("t3_mask", mismatch_mask, 16'h0200);
        chk("t3_err", err_count, 5'd1);
`ifdef TTS_STOP_ON_FAIL_EN
        chk("t3_latency", n, 20);
        chk("t3_vec", vec_out, 4'd9);
        chk("t3_table", table_out, 16'h0155);
        tick(); tick();
        chk("t3_vec_held", vec_out, 4'd9);
`else
        chk("t3_latency", n, 32);
        chk("t3_table", table_out, 16'h1D55);
        tick();
`endif

        // start re-pulsed mid-sweep is ignored
        mode = 0;
        pulse_start();
        n = 0;
        pulsed = 1'b0;
        while (!done && n < 200) begin
            if (vec_out == 4'd5 && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk("t4_repulsed", pulsed, 1'b1);
        chk("t4_latency", n, 32);
        chk("t4_pass", pass, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        chk("t4_no_second_sweep", done_seen, 0);

        // reset in the middle of a sweep
        pulse_start();
        k = 0;
        while (vec_out != 4'd7 && k < 200) begin
            tick();
            k++;
        end
        chk("t5_reached_vec7", vec_out, 4'd7);
        chk("t5_partial_table", table_out, 16'h0055);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_vec", vec_out, 4'd0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_table", table_out, 16'h0000);
        chk("t5_rst_mask", mismatch_mask, 16'h0000);
        chk("t5_rst_err", err_count, 5'd0);
        chk("t5_rst_pass", pass, 1'b0);
        tick();
        chk("t5_idle_after_rst", busy, 1'b0);
        pulse_start();
        wait_done(n);
        chk("t5_resweep_latency", n, 32);
        chk("t5_resweep_pass", pass, 1'b1);
        chk("t5_resweep_table", table_out, 16'h1F55);

        // SETTLE_CYCLES = 3 with a slow function
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0; run = 1; bad = 0; changes = 0;
        prev = vec_out3;
        while (!done3 && n < 400) begin
            tick();
            n++;
            if (vec_out3 != prev) begin
                if (run != 4) bad++;
                changes++;
                run = 1;
                prev = vec_out3;
            end else begin
                run++;
            end
        end
        chk("t6_latency", n, 64);
        chk("t6_hold_len_errors", bad, 0);
        chk("t6_vec_changes", changes, 15);
        chk("t6_pass", pass3, 1'b1);
        chk("t6_table", table_out3, 16'h1F55);
        chk("t6_err", err_count3, 5'd0);
        tick();
        chk("t6_done_pulse", done3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
